// File: rtl/ieee754_pkg.sv
// ieee754_pkg
//   Shared definitions for the IEEE754 single-precision significand
//   multiplier: controller state encoding, field widths, exponent bias,
//   bit positions inside the {nan, inf, zero} flags vector and the
//   operand classification record produced by ieee754_unpack.
package ieee754_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int EXP_BIAS = 127;
  localparam int FRAC_W   = 23;
  localparam int EXP_W    = 8;
  localparam int SIG_W    = 24;
  localparam int PROD_W   = 48;
  localparam int ESUM_W   = 10;
  localparam int CNT_W    = 5;

  localparam int FLAGS_W   = 3;
  localparam int FLAG_NAN  = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 0;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic inf;
    logic nan;
  } op_class_t;

endpackage

// File: rtl/ieee754_unpack.sv
// ieee754_unpack
//   Splits one single-precision operand into its fields and classifies it.
//   Ports:
//     op      in  32  IEEE754 single-precision value
//     sign    out 1   sign bit
//     exp_raw out 8   biased exponent field as stored
//     sig     out 24  significand with the hidden bit made explicit
//                     (hidden bit is 0 for zero/denormal encodings)
//     cls     out 4   class bits {zero, denorm, inf, nan}
import ieee754_pkg::*;

module ieee754_unpack (
  input  logic [31:0]      op,
  output logic             sign,
  output logic [EXP_W-1:0] exp_raw,
  output logic [SIG_W-1:0] sig,
  output op_class_t        cls
);

  logic [FRAC_W-1:0] frac;
  logic              exp_nz;
  logic              exp_max;
  logic              frac_nz;

  always_comb begin
    sign    = op[31];
    exp_raw = op[30:23];
    frac    = op[22:0];
    exp_nz  = |exp_raw;
    exp_max = &exp_raw;
    frac_nz = |frac;

    sig = {exp_nz, frac};

    cls.zero   = !exp_nz && !frac_nz;
    cls.denorm = !exp_nz &&  frac_nz;
    cls.inf    =  exp_max && !frac_nz;
    cls.nan    =  exp_max &&  frac_nz;
  end

endmodule

// File: rtl/ieee754_mant_mul.sv
// ieee754_mant_mul
//   Iterative shift-and-add multiplier for the significands of two IEEE754
//   single-precision operands. Produces the raw 48-bit significand product
//   plus the biased exponent sum and result sign for a downstream
//   normalizer. BITS_PER_CYCLE multiplier bits are retired per BUSY cycle
//   (legal: 1, 2, 3, 4, 6, 8, 12, 24); a result appears 24/BITS_PER_CYCLE+1
//   edges after the accepting edge.
//
//   Optional feature: define IEEE754_MUL_SPECIAL_EN to classify NaN/inf/zero
//   operands at accept time; a flagged operation bypasses the iterations and
//   reports product=0 two edges after accept. Without the macro, flags is
//   tied to 0 and every operand pair takes the full iterative path.
//
//   Ports:
//     clk        in  1   rising-edge clock
//     reset      in  1   asynchronous active-high reset
//     in_valid   in  1   operands a/b present
//     in_ready   out 1   high only in IDLE
//     a, b       in  32  IEEE754 single-precision operands
//     out_valid  out 1   high only in DONE
//     out_ready  in  1   consumer takes the result
//     product    out 48  raw significand product
//     exp_sum    out 10  two's-complement ea+eb-127 (denormals use exponent 1)
//     sign       out 1   a[31] ^ b[31]
//     flags      out 3   {nan, inf, zero}
import ieee754_pkg::*;

module ieee754_mant_mul #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   product,
  output logic [ESUM_W-1:0]   exp_sum,
  output logic                sign,
  output logic [FLAGS_W-1:0]  flags
);

  localparam int ITER = SIG_W / BITS_PER_CYCLE;

`ifdef IEEE754_MUL_SPECIAL_EN
  localparam bit SPECIAL_EN = 1'b1;
`else
  localparam bit SPECIAL_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SIG_W-1:0]    ma_q, ma_d;
  logic [SIG_W-1:0]    mb_q, mb_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [ESUM_W-1:0]   exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [FLAGS_W-1:0]  flags_q, flags_d;

  // Operand unpacking
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp_raw, b_exp_raw;
  logic [SIG_W-1:0] a_sig, b_sig;
  op_class_t        a_cls, b_cls;

  ieee754_unpack u_unpack_a (
    .op      (a),
    .sign    (a_sign),
    .exp_raw (a_exp_raw),
    .sig     (a_sig),
    .cls     (a_cls)
  );

  ieee754_unpack u_unpack_b (
    .op      (b),
    .sign    (b_sign),
    .exp_raw (b_exp_raw),
    .sig     (b_sig),
    .cls     (b_cls)
  );

  logic [EXP_W-1:0]   a_exp_eff, b_exp_eff;
  logic [ESUM_W-1:0]  exp_in;
  logic [FLAGS_W-1:0] flags_in;
  logic [PROD_W-1:0]  partial;
  logic [PROD_W-1:0]  addend;
  logic [5:0]         shamt;

  // Accept-time operand decode: effective exponents, exponent sum, classes
  always_comb begin
    // Zero and denormal encodings both sit at the minimum exponent of 1.
    a_exp_eff = (a_cls.zero || a_cls.denorm) ? EXP_W'(1) : a_exp_raw;
    b_exp_eff = (b_cls.zero || b_cls.denorm) ? EXP_W'(1) : b_exp_raw;
    exp_in    = ESUM_W'(a_exp_eff) + ESUM_W'(b_exp_eff) - ESUM_W'(EXP_BIAS);

    flags_in = '0;
    flags_in[FLAG_NAN]  = a_cls.nan || b_cls.nan ||
                          (a_cls.inf && b_cls.zero) || (b_cls.inf && a_cls.zero);
    flags_in[FLAG_INF]  = (a_cls.inf || b_cls.inf) && !flags_in[FLAG_NAN];
    flags_in[FLAG_ZERO] = (a_cls.zero || b_cls.zero) && !flags_in[FLAG_NAN];
    if (!SPECIAL_EN) begin
      flags_in = '0;
    end
  end

  // Iteration datapath: one radix-2^BITS_PER_CYCLE partial product per cycle
  always_comb begin
    partial = PROD_W'(ma_q) * PROD_W'(mb_q[BITS_PER_CYCLE-1:0]);
    shamt   = 6'(int'(count_q) * BITS_PER_CYCLE);
    addend  = partial << shamt;
  end

  // Controller next-state and register updates
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    flags_d = flags_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          count_d = '0;
          ma_d    = a_sig;
          mb_d    = b_sig;
          acc_d   = '0;
          exp_d   = exp_in;
          sign_d  = a_sign ^ b_sign;
          flags_d = flags_in;
        end
      end
      BUSY: begin
        if (|flags_q) begin
          // Special operand: result is fully described by the flags.
          state_d = DONE;
          acc_d   = '0;
        end else begin
          acc_d   = acc_q + addend;
          mb_d    = mb_q >> BITS_PER_CYCLE;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(ITER - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;
  assign exp_sum   = exp_q;
  assign sign      = sign_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_ieee754_mant_mul.sv
module tb_ieee754_mant_mul;

  localparam int BPC  = 2;
  localparam int ITER = 24 / BPC;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;

  logic        in_ready_m, out_valid_m, sign_m;
  logic [47:0] product_m;
  logic [9:0]  exp_sum_m;
  logic [2:0]  flags_m;

  logic        in_ready_1, out_valid_1, sign_1;
  logic [47:0] product_1;
  logic [9:0]  exp_sum_1;
  logic [2:0]  flags_1;

  logic        in_ready_24, out_valid_24, sign_24;
  logic [47:0] product_24;
  logic [9:0]  exp_sum_24;
  logic [2:0]  flags_24;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ieee754_mant_mul #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
    .a(a), .b(b), .out_valid(out_valid_m), .out_ready(out_ready),
    .product(product_m), .exp_sum(exp_sum_m), .sign(sign_m), .flags(flags_m)
  );

  ieee754_mant_mul #(.BITS_PER_CYCLE(1)) dut_bpc1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_1),
    .a(a), .b(b), .out_valid(out_valid_1), .out_ready(out_ready),
    .product(product_1), .exp_sum(exp_sum_1), .sign(sign_1), .flags(flags_1)
  );

  ieee754_mant_mul #(.BITS_PER_CYCLE(24)) dut_bpc24 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_24),
    .a(a), .b(b), .out_valid(out_valid_24), .out_ready(out_ready),
    .product(product_24), .exp_sum(exp_sum_24), .sign(sign_24), .flags(flags_24)
  );

  // Reference: real significand product from the encodings, plain integer math.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [47:0] p, output logic [9:0] e,
                                output logic s, output logic [2:0] f,
                                output int lat);
    longint mx, my;
    int ex, ey;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'(x[22:0]);
    my = longint'(y[22:0]);
    if (ex != 0) mx = mx + 64'd8388608;
    if (ey != 0) my = my + 64'd8388608;
    p = 48'(mx * my);
    e = 10'(((ex == 0) ? 1 : ex) + ((ey == 0) ? 1 : ey) - 127);
    s = x[31] ^ y[31];
    f = 3'b000;
    lat = ITER + 1;
`ifdef IEEE754_MUL_SPECIAL_EN
    begin
      bit xz, yz, xi, yi, xn, yn;
      xz = (ex == 0)   && (x[22:0] == 0);
      yz = (ey == 0)   && (y[22:0] == 0);
      xi = (ex == 255) && (x[22:0] == 0);
      yi = (ey == 255) && (y[22:0] == 0);
      xn = (ex == 255) && (x[22:0] != 0);
      yn = (ey == 255) && (y[22:0] != 0);
      if (xn || yn || (xi && yz) || (yi && xz)) f = 3'b100;
      else if (xi || yi)                        f = 3'b010;
      else if (xz || yz)                        f = 3'b001;
      if (f != 3'b000) begin
        p = '0;
        lat = 2;
      end
    end
`endif
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:0] = '0;
      1: v[30:23] = 8'h00;
      2: v[30:23] = 8'hFF;
      3: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      4: v[22:0] = 23'h7FFFFF;
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand pair for exactly the accepting
  // edge, then counts edges (accepting edge = 1) until out_valid is seen.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_op, output int lat);
    int guard = 0;
    while (!in_ready_m && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (in_ready_m !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got in_ready=%0b want 1", in_ready_m);
    end
    a = ta;
    b = tb_op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_m && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    #3;
    checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake got in_ready=%0b out_valid=%0b want 1/0", in_ready_m, out_valid_m);
    end
    checks++;
    if (product_m !== 48'h0 || exp_sum_m !== 10'h0) begin
      failures++;
      $display("FAIL reset_data got product=%h exp_sum=%h want 0/0", product_m, exp_sum_m);
    end
    checks++;
    if (sign_m !== 1'b0 || flags_m !== 3'b000) begin
      failures++;
      $display("FAIL reset_sign_flags got sign=%0b flags=%b want 0/000", sign_m, flags_m);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] ta [3] = '{32'h3F800000, 32'h40000000, 32'h3FFFFFFF};
    logic [31:0] tb_v [3] = '{32'h3F800000, 32'hC0400000, 32'h3FFFFFFF};
    logic [47:0] ep [3] = '{48'h400000000000, 48'h600000000000, 48'hFFFFFE000001};
    logic [9:0]  ee [3] = '{10'd127, 10'd129, 10'd127};
    logic        es [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb_v[i], lat);
      checks++;
      if (lat != ITER + 1 || out_valid_m !== 1'b1) begin
        failures++;
        $display("FAIL directed%0d_latency got %0d want %0d", i, lat, ITER + 1);
      end
      checks++;
      if (product_m !== ep[i]) begin
        failures++;
        $display("FAIL directed%0d_product got %h want %h", i, product_m, ep[i]);
      end
      checks++;
      if (exp_sum_m !== ee[i] || sign_m !== es[i] || flags_m !== 3'b000) begin
        failures++;
        $display("FAIL directed%0d_exp_sign got exp=%0d sign=%0b flags=%b want exp=%0d sign=%0b flags=000",
                 i, exp_sum_m, sign_m, flags_m, ee[i], es[i]);
      end
    end
    tick();
  endtask

  // Backpressure hold plus operand/in_valid noise while busy and while done.
  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    a = 32'h3FFFFFFF;
    b = 32'h3FFFFFFF;
    in_valid = 1'b1;
    tick();
    lat = 1;
    while (!out_valid_m && lat < 100) begin
      a = $urandom;
      b = $urandom;
      tick();
      lat++;
    end
    checks++;
    if (lat != ITER + 1) begin
      failures++;
      $display("FAIL hold_latency got %0d want %0d", lat, ITER + 1);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || product_m !== 48'hFFFFFE000001 ||
          exp_sum_m !== 10'd127 || sign_m !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got valid=%0b ready=%0b product=%h exp=%0d sign=%0b want 1/0/fffffe000001/127/0",
                 c, out_valid_m, in_ready_m, product_m, exp_sum_m, sign_m);
      end
      a = $urandom;
      b = $urandom;
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got valid=%0b ready=%0b want 0/1 (no same-edge accept)", out_valid_m, in_ready_m);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    int lat;
    a = 32'h40000000;
    b = 32'h40400000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || product_m !== 48'h0 || exp_sum_m !== 10'h0) begin
      failures++;
      $display("FAIL reset_busy got valid=%0b ready=%0b product=%h exp=%h want 0/1/0/0",
               out_valid_m, in_ready_m, product_m, exp_sum_m);
    end
    #2;
    reset = 1'b0;
    issue(32'h3F800000, 32'h3F800000, lat);
    checks++;
    if (lat != ITER + 1 || product_m !== 48'h400000000000 || exp_sum_m !== 10'd127 || sign_m !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_next got lat=%0d product=%h exp=%0d sign=%0b want %0d/400000000000/127/0",
               lat, product_m, exp_sum_m, sign_m, ITER + 1);
    end
    tick();
  endtask

  task automatic test_special();
    logic [31:0] ta [4] = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'hFF800000};
    logic [31:0] tb_v [4] = '{32'h3F800000, 32'h00000000, 32'h40000000, 32'h3F800000};
    logic [47:0] ep;
    logic [9:0]  ee;
    logic        es;
    logic [2:0]  ef;
    int elat, lat;
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb_v[i], ep, ee, es, ef, elat);
      issue(ta[i], tb_v[i], lat);
      checks++;
      if (lat != elat || flags_m !== ef || product_m !== ep || exp_sum_m !== ee || sign_m !== es) begin
        failures++;
        $display("FAIL special%0d got lat=%0d flags=%b product=%h exp=%0d sign=%0b want %0d/%b/%h/%0d/%0b",
                 i, lat, flags_m, product_m, exp_sum_m, sign_m, elat, ef, ep, ee, es);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic [47:0] ep;
    logic [9:0]  ee;
    logic        es;
    logic [2:0]  ef;
    int elat, lat;
    for (int i = 0; i < 40; i++) begin
      ra = rand_op();
      rb = rand_op();
      model(ra, rb, ep, ee, es, ef, elat);
      issue(ra, rb, lat);
      checks++;
      if (lat != elat || product_m !== ep || exp_sum_m !== ee || sign_m !== es || flags_m !== ef) begin
        failures++;
        $display("FAIL random%0d a=%h b=%h got lat=%0d product=%h exp=%h sign=%0b flags=%b want %0d/%h/%h/%0b/%b",
                 i, ra, rb, lat, product_m, exp_sum_m, sign_m, flags_m, elat, ep, ee, es, ef);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  task automatic test_bpc_variants();
    int l1 = 0, l24 = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    a = 32'h3F800000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (out_valid_1 && l1 == 0) l1 = n;
      if (out_valid_24 && l24 == 0) l24 = n;
      if (n < 30) tick();
    end
    checks++;
    if (l1 != 25 || product_1 !== 48'h400000000000 || exp_sum_1 !== 10'd127 || sign_1 !== 1'b0 || flags_1 !== 3'b000) begin
      failures++;
      $display("FAIL bpc1 got lat=%0d product=%h exp=%0d want 25/400000000000/127", l1, product_1, exp_sum_1);
    end
    checks++;
    if (l24 != 2 || product_24 !== 48'h400000000000 || exp_sum_24 !== 10'd127 || sign_24 !== 1'b0 || flags_24 !== 3'b000) begin
      failures++;
      $display("FAIL bpc24 got lat=%0d product=%h exp=%0d want 2/400000000000/127", l24, product_24, exp_sum_24);
    end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_busy();
    test_special();
    test_random();
    test_bpc_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ieee754_mant_mul.md
IEEE754_MANT_MUL -- requirements
Module: ieee754_mant_mul

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 2, multiplier bits retired per iteration; legal values 1, 2, 3, 4, 6, 8, 12, 24.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operands a/b present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports a, b  input  32 each  IEEE754 single-precision operands.
REQ-007 SHALL have port out_valid  output  1  result present.
REQ-008 SHALL have port out_ready  input  1  consumer (normalizer stage) takes result.
REQ-009 SHALL have port product  output  48  raw significand product, the normalizer input.
REQ-010 SHALL have port exp_sum  output  10  two's-complement biased exponent ea+eb-127.
REQ-011 SHALL have port sign  output  1  a[31] XOR b[31].
REQ-012 SHALL have port flags  output  3  {nan, inf, zero}.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; ITER = 24/BITS_PER_CYCLE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept on clock edge with in_valid && in_ready: latch sign, exp_sum, significands; clear accumulator and counter; go to BUSY.
REQ-016 Significand SHALL be {exp!=0, frac}; denormal operands use exponent 1 in exp_sum.
REQ-017 Each BUSY edge SHALL add (ma * low BITS_PER_CYCLE bits of mb) << (count*BITS_PER_CYCLE) into the 48-bit accumulator, shift mb right, increment count.
REQ-018 After ITER BUSY edges, SHALL enter DONE; out_valid first visible ITER+1 edges after the accepting edge (13 for default).
REQ-019 In DONE with out_ready=0, product, exp_sum, sign, flags SHALL hold stable.
REQ-020 DONE with out_ready=1 SHALL return to IDLE on that edge; no operand accepted on the same edge.
REQ-021 in_valid while not in IDLE SHALL be ignored; a/b changes during BUSY SHALL not affect the result.
REQ-022 Accumulator SHALL never overflow: product <= 0xFFFFFE000001.

Reset
REQ-023 reset SHALL asynchronously force IDLE, in_ready=1, out_valid=0, product=0, exp_sum=0, sign=0, flags=0, counter=0.
REQ-024 reset in BUSY or DONE SHALL discard the operation; first accept permitted on first edge after deassertion.

Configuration
REQ-025 Macro IEEE754_MUL_SPECIAL_EN defined: at accept, flags.nan = either operand NaN, or inf*0; flags.inf = either inf and not nan; flags.zero = either operand zero and not nan; any flag set SHALL skip BUSY (DONE on next edge, latency 2) with product=0.
REQ-026 Macro undefined: flags port SHALL remain and be driven 0; all operands take the full iterative path.

Structure
REQ-027 Package ieee754_pkg SHALL hold state enum, EXP_BIAS=127, FRAC_W=23, SIG_W=24, PROD_W=48, flag bit indices.
REQ-028 Sub-module ieee754_unpack SHALL split one operand into sign, exponent, significand, and class bits (zero/denorm/inf/nan); instantiated twice.

Verification
REQ-029 a=0x3F800000, b=0x3F800000 -> product=0x400000000000, exp_sum=127, sign=0, out_valid at edge 13.
REQ-030 a=0x40000000, b=0xC0400000 -> product=0x600000000000, exp_sum=129, sign=1.
REQ-031 a=b=0x3FFFFFFF -> product=0xFFFFFE000001, exp_sum=127; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
REQ-032 reset pulsed at BUSY count 5 -> out_valid=0, in_ready=1 immediately; next op 0x3F800000*0x3F800000 gives the REQ-029 result.
REQ-033 IEEE754_MUL_SPECIAL_EN: a=0x7FC00000, b=0x3F800000 -> flags=3'b100, product=0, out_valid at edge 2; a=0x7F800000, b=0 -> flags=3'b100.
REQ-034 BITS_PER_CYCLE=1 and 24 -> REQ-029 values with latency 25 and 2 respectively.
